label_table_reader: RTL
=======================

// Module: label_table_reader
// PURPOSE
// - Post-frame reader for the CCL merge table and data table written by the labeler.
// - After start: walks labels 1..num_labels-1 and resolves each to its root by chasing merge-table links.
// - Emits one object record per label {label, root, data} on a valid/ready stream.
// - Sits between the labeler's table RAMs (second read ports) and the object aggregation/bbox stage.
// PARAMETERS
// - WORD_SIZE   8    label/address width; matches `WORD_SIZE
// - DATA_WIDTH  24   data-table entry width
// - MAX_HOPS    255  max merge links followed per label before error
// PORTS
// - clk         in   1           clock; single clock domain
// - reset       in   1           synchronous, active-high reset
// - start       in   1           begin read-out; sampled only in IDLE
// - num_labels  in   WORD_SIZE   next-free label count from labeler; latched on accepted start
// - mt_addr     out  WORD_SIZE   merge-table read address
// - mt_q        in   WORD_SIZE   merge-table read data; valid 1 cycle after mt_addr
// - dt_addr     out  WORD_SIZE   data-table read address
// - dt_q        in   DATA_WIDTH  data-table read data; valid 1 cycle after dt_addr
// - obj_valid   out  1           record valid
// - obj_ready   in   1           downstream accepts record
// - obj_label   out  WORD_SIZE   original label
// - obj_root    out  WORD_SIZE   resolved root label
// - obj_data    out  DATA_WIDTH  data-table entry of obj_label
// - busy        out  1           high from cycle after accepted start until done
// - done        out  1           one-cycle pulse at end of pass
// - err         out  1           sticky: bad link or hop limit hit; cleared by next accepted start
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 (addresses, obj_*, busy, done, err).
// - States: IDLE, FETCH, CHECK, CHASE, EMIT, FIN.
// - IDLE: start=1 -> latch n=num_labels, clear err; i=1. Next state is FETCH if n>1, else FIN.
// - FETCH (1 cyc): mt_addr=dt_addr=i; hops=0 -> CHECK.
// - CHECK: capture dt_q into data; evaluate link=mt_q against node (node=i at entry from FETCH).
// - Link evaluation, priority order:
//   - link==node -> root=node -> EMIT.
//   - link==0 or link>=n -> err=1, root=node -> EMIT.
//   - hops==MAX_HOPS -> err=1, root=node -> EMIT.
//   - otherwise node=link, hops++, mt_addr=link -> CHASE.
// - CHASE (1 cyc, read latency) -> CHECK. dt_q is not recaptured while chasing.
// - EMIT: obj_valid=1. obj_label/obj_root/obj_data stay stable while obj_valid && !obj_ready.
// - EMIT handshake (valid&&ready): obj_valid drops next cycle; i++; if i==n-1 -> FIN, else FETCH.
// - FIN: done=1 for exactly one cycle, busy=0 -> IDLE.
// - Timing: start in cycle 0 -> busy=1 from cycle 1.
// - Timing: identity link gives obj_valid in cycle 3; each hop adds 2 cycles.
// - Timing: num_labels<=1 -> done in cycle 2, no records.
// - start while busy: ignored.
// - reset mid-pass: IDLE next cycle, no done pulse, pending record dropped.
// - Arithmetic: i and hops are unsigned WORD_SIZE; n<=2^WORD_SIZE-1, so i never wraps.
// CONFIGURATION
// - Macro LABEL_READER_SKIP_EMPTY_EN.
// - Defined: labels with dt_q==0 emit no record. CHECK goes straight to next label (i++ -> FETCH, or FIN if last); no chase.
// - Not defined: every label 1..n-1 emits exactly one record, including zero-data labels.
// TESTING
// - num_labels=1, start -> busy cycle 1 only, done pulse cycle 2, obj_valid never high.
// - n=4, MT identity, DT[1..3]=10,20,30, ready=1 -> records (1,1,10),(2,2,20),(3,3,30); done; err=0.
// - n=4, MT[1]=1, MT[2]=1, MT[3]=2 -> label 3 root 1 after 2 hops; obj_valid 4 cycles later than identity.
// - Backpressure: ready=0 for 5 cycles during a record -> fields stable, no record lost/duplicated.
// - MAX_HOPS=4, MT[2]=3, MT[3]=2 -> err=1; labels 2,3 still emitted; pass completes; next start clears err.
// - MT[2]=7 with n=4 -> err=1, root 2. With SKIP_EMPTY_EN and DT[2]=0 -> labels 1,3 only.
// - reset asserted while EMIT stalled -> obj_valid=0 next cycle, no done, clean pass on next start.

Source files
------------

// File: rtl/label_table_reader_if.sv
// Table-read ports and object-record stream of label_table_reader.
// master = reader side; slave = table RAMs plus downstream consumer.
interface label_table_reader_if #(
   parameter int unsigned WORD_SIZE  = 8,
   parameter int unsigned DATA_WIDTH = 24
);
   logic [WORD_SIZE-1:0]  mt_addr;
   logic [WORD_SIZE-1:0]  mt_q;
   logic [WORD_SIZE-1:0]  dt_addr;
   logic [DATA_WIDTH-1:0] dt_q;
   logic                  obj_valid;
   logic                  obj_ready;
   logic [WORD_SIZE-1:0]  obj_label;
   logic [WORD_SIZE-1:0]  obj_root;
   logic [DATA_WIDTH-1:0] obj_data;

   modport master (
      output mt_addr, dt_addr, obj_valid, obj_label, obj_root, obj_data,
      input  mt_q, dt_q, obj_ready
   );

   modport slave (
      input  mt_addr, dt_addr, obj_valid, obj_label, obj_root, obj_data,
      output mt_q, dt_q, obj_ready
   );
endinterface

// File: rtl/label_table_reader.sv
// Post-frame CCL reader: resolves labels 1..n-1 to merge roots, streams {label, root, data}.
// Define LABEL_READER_SKIP_EMPTY_EN to drop labels whose data-table entry is zero.
module label_table_reader #(
   parameter int unsigned WORD_SIZE  = 8,
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned MAX_HOPS   = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WORD_SIZE-1:0] num_labels,
   label_table_reader_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   typedef enum logic [2:0] {StIdle, StFetch, StCheck, StChase, StEmit, StFin} state_e;

   localparam logic [WORD_SIZE-1:0] One     = WORD_SIZE'(1);
   localparam logic [WORD_SIZE-1:0] MaxHops = WORD_SIZE'(MAX_HOPS);

   state_e                state_q;
   logic [WORD_SIZE-1:0]  n_q, i_q, node_q, hops_q;
   logic [WORD_SIZE-1:0]  mt_addr_q, dt_addr_q, label_q, root_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q, busy_q, done_q, err_q;
   logic [WORD_SIZE-1:0]  link;
   logic                  last;
   logic                  skip;

   assign link = bus.mt_q;
   assign last = (i_q == n_q - One);

`ifdef LABEL_READER_SKIP_EMPTY_EN
   // Only the first CHECK of a label sees that label's data-table entry.
   assign skip = (hops_q == '0) && (bus.dt_q == '0);
`else
   assign skip = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         n_q       <= '0;
         i_q       <= '0;
         node_q    <= '0;
         hops_q    <= '0;
         mt_addr_q <= '0;
         dt_addr_q <= '0;
         label_q   <= '0;
         root_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  n_q       <= num_labels;
                  err_q     <= 1'b0;
                  busy_q    <= 1'b1;
                  i_q       <= One;
                  mt_addr_q <= One;
                  dt_addr_q <= One;
                  state_q   <= (num_labels > One) ? StFetch : StFin;
               end
            end
            StFetch: begin
               mt_addr_q <= i_q;
               dt_addr_q <= i_q;
               node_q    <= i_q;
               hops_q    <= '0;
               state_q   <= StCheck;
            end
            StCheck: begin
               if (hops_q == '0) data_q <= bus.dt_q;
               if (skip) begin
                  if (last) begin
                     state_q <= StFin;
                  end else begin
                     i_q       <= i_q + One;
                     mt_addr_q <= i_q + One;
                     dt_addr_q <= i_q + One;
                     state_q   <= StFetch;
                  end
               end else if (link == node_q) begin
                  root_q  <= node_q;
                  label_q <= i_q;
                  valid_q <= 1'b1;
                  state_q <= StEmit;
               end else if ((link == '0) || (link >= n_q) || (hops_q == MaxHops)) begin
                  err_q   <= 1'b1;
                  root_q  <= node_q;
                  label_q <= i_q;
                  valid_q <= 1'b1;
                  state_q <= StEmit;
               end else begin
                  node_q    <= link;
                  hops_q    <= hops_q + One;
                  mt_addr_q <= link;
                  state_q   <= StChase;
               end
            end
            StChase: state_q <= StCheck;
            StEmit: begin
               if (bus.obj_ready) begin
                  valid_q <= 1'b0;
                  if (last) begin
                     state_q <= StFin;
                  end else begin
                     i_q       <= i_q + One;
                     mt_addr_q <= i_q + One;
                     dt_addr_q <= i_q + One;
                     state_q   <= StFetch;
                  end
               end
            end
            StFin: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.mt_addr   = mt_addr_q;
   assign bus.dt_addr   = dt_addr_q;
   assign bus.obj_valid = valid_q;
   assign bus.obj_label = label_q;
   assign bus.obj_root  = root_q;
   assign bus.obj_data  = data_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
endmodule
